// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types and constants for the ramped PWM generator:
//            fade-state encoding, key-bit indices and the duty preset table.
// Ports    : none (package)
// Config   : PWM_FADE_EN (fade_state_t is only used when it is defined)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Ramp direction of one channel's active duty relative to its target.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_t;

  // Bit positions inside each channel's 4-bit key group; lower index wins.
  localparam int KEY_MAX  = 0;
  localparam int KEY_HALF = 1;
  localparam int KEY_20   = 2;
  localparam int KEY_OFF  = 3;

  // Preset duty for a key index at a given resolution.
  // MAXD = 2^res_bits - 1; the 20% preset truncates (MAXD/5).
  function automatic int unsigned preset_duty(input int key_idx, input int res_bits);
    int unsigned maxd;
    maxd = (32'd1 << res_bits) - 32'd1;
    case (key_idx)
      KEY_MAX:  return maxd;
      KEY_HALF: return maxd >> 1;
      KEY_20:   return maxd / 32'd5;
      default:  return 32'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM channel: key decode into a target duty, active duty that
//            only moves on the update strobe (direct load, or +/-1 ramp when
//            fading), phase compare and registered output.
// Ports    : CLK, RSTn       - clock, async active-low reset
//            keys[3:0]       - key pulses {off, 20%, half, max}
//            phase           - shared phase counter
//            duty_update     - strobe on which active duty may change
//            pwm_out         - registered (phase < active)
//            busy            - active duty differs from target duty
// Config   : PWM_FADE_EN - ramp active toward target instead of loading it
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int RES_BITS = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [3:0]          keys,
  input  logic [RES_BITS-1:0] phase,
  input  logic                duty_update,
  output logic                pwm_out,
  output logic                busy
);

  localparam logic [RES_BITS-1:0] c_duty_max  = RES_BITS'(preset_duty(KEY_MAX,  RES_BITS));
  localparam logic [RES_BITS-1:0] c_duty_half = RES_BITS'(preset_duty(KEY_HALF, RES_BITS));
  localparam logic [RES_BITS-1:0] c_duty_20   = RES_BITS'(preset_duty(KEY_20,   RES_BITS));
  localparam logic [RES_BITS-1:0] c_duty_off  = RES_BITS'(preset_duty(KEY_OFF,  RES_BITS));

  logic [RES_BITS-1:0] r_target;
  logic [RES_BITS-1:0] r_active;
  logic [RES_BITS-1:0] w_key_duty;
  logic                w_key_hit;

  // Priority decode: max > half > 20% > off.
  always_comb begin
    w_key_hit  = |keys;
    w_key_duty = c_duty_off;
    if (keys[KEY_MAX])       w_key_duty = c_duty_max;
    else if (keys[KEY_HALF]) w_key_duty = c_duty_half;
    else if (keys[KEY_20])   w_key_duty = c_duty_20;
    else                     w_key_duty = c_duty_off;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_target <= '0;
    end else if (w_key_hit) begin
      r_target <= w_key_duty;
    end
  end

`ifdef PWM_FADE_EN
  localparam logic [RES_BITS-1:0] c_one = RES_BITS'(1);

  fade_state_t w_state;

  // Direction is re-evaluated every cycle, so a target change mid-ramp
  // simply redirects from the current active value.
  always_comb begin
    w_state = IDLE;
    if (r_target > r_active)      w_state = UP;
    else if (r_target < r_active) w_state = DOWN;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_active <= '0;
    end else if (duty_update) begin
      case (w_state)
        UP:      r_active <= r_active + c_one;
        DOWN:    r_active <= r_active - c_one;
        default: r_active <= r_active;
      endcase
    end
  end
`else
  // Active samples the pre-edge target, so a key on the boundary edge
  // takes effect one period later.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_active <= '0;
    end else if (duty_update) begin
      r_active <= r_target;
    end
  end
`endif

  // Strict compare: duty MAXD leaves one phase step low each period.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (phase < r_active);
    end
  end

  assign busy = (r_active != r_target);

endmodule
`default_nettype wire

// File: rtl/ramped_pwm_module.sv
`default_nettype none
// ============================================================================
// Module   : ramped_pwm_module
// Purpose  : Multi-channel PWM generator with key-selected duty presets.
//            Shared prescaler and phase counter; per-channel duty applied only
//            at period boundaries (optionally ramped one step at a time).
// Ports    : CLK, RSTn       - clock, async active-low reset
//            option_keys     - 4 key-pulse bits per channel
//            pwm_out         - registered PWM outputs
//            busy            - per channel, active duty != target duty
//            period_start    - one-cycle pulse on first cycle of each period
// Config   : PWM_FADE_EN - enables step counter and per-channel ramping
// Revision : 1.0 - initial release
// ============================================================================
module ramped_pwm_module
  import pwm_pkg::*;
#(
  parameter int CLK_DIV      = 195,
  parameter int RES_BITS     = 8,
  parameter int CHANNELS     = 4,
  parameter int STEP_PERIODS = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [4*CHANNELS-1:0] option_keys,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic [CHANNELS-1:0]   busy,
  output logic                  period_start
);

  localparam logic [15:0]         c_div_last  = 16'(CLK_DIV - 1);
  localparam logic [RES_BITS-1:0] c_phase_one = RES_BITS'(1);

  logic [15:0]         r_prescale;
  logic [RES_BITS-1:0] r_phase;
  logic                w_tick;
  logic                w_period_end;
  logic                w_duty_update;

  generate
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
      $error("CLK_DIV out of range 2..65535");
    end
    if (STEP_PERIODS < 1 || STEP_PERIODS > 255) begin : g_bad_step
      $error("STEP_PERIODS out of range 1..255");
    end
  endgenerate

  assign w_tick       = (r_prescale == c_div_last);
  assign w_period_end = w_tick && (&r_phase);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + 16'd1;
    end
  end

  // Natural wrap from all-ones to zero closes each period.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_phase <= '0;
    end else if (w_tick) begin
      r_phase <= r_phase + c_phase_one;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      period_start <= 1'b0;
    end else begin
      period_start <= w_period_end;
    end
  end

`ifdef PWM_FADE_EN
  localparam logic [7:0] c_step_last = 8'(STEP_PERIODS - 1);

  logic [7:0] r_step_cnt;

  // Shared across channels so all ramps advance on the same boundaries.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_step_cnt <= '0;
    end else if (w_period_end) begin
      if (r_step_cnt == c_step_last) r_step_cnt <= '0;
      else                           r_step_cnt <= r_step_cnt + 8'd1;
    end
  end

  assign w_duty_update = w_period_end && (r_step_cnt == c_step_last);
`else
  assign w_duty_update = w_period_end;
`endif

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      pwm_channel #(
        .RES_BITS (RES_BITS)
      ) u_channel (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .keys        (option_keys[4*gi +: 4]),
        .phase       (r_phase),
        .duty_update (w_duty_update),
        .pwm_out     (pwm_out[gi]),
        .busy        (busy[gi])
      );
    end
  endgenerate

endmodule
`default_nettype wire
